vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA/raster timing generator that produces horizontal and vertical sync, data-enable, pixel coordinates and frame/line start strobes for any resolution. Porch, sync and active widths and the sync polarities are all parameters. A pixel-clock enable lets the block run from a faster system clock. It sits between the clock/reset logic and the pixel-generation pipeline. Defaults give the standard 640x480@60 Hz mode with a 25 MHz pixel rate.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 11, counter width; 2^CW must exceed both H_TOTAL and V_TOTAL
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pix_en  in  1  pixel-rate clock enable; the counters advance only on clk edges where pix_en=1
- resync  in  1  synchronous frame restart
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, high in the active area
- hcnt  out  CW  horizontal position; equals x when de=1
- vcnt  out  CW  vertical position; equals y when de=1
- line_start  out  1  one-clk strobe when hcnt becomes 0
- frame_start  out  1  one-clk strobe when (hcnt,vcnt) becomes (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Line layout, hcnt 0..H_TOTAL-1, in order:
  - active: 0..H_ACTIVE-1
  - front porch
  - sync: H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1 (656..751)
  - back porch
- The frame uses the same layout on vcnt. Vertical sync spans 490..491.
- Horizontal counter: on an enabled edge, hcnt increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: vcnt increments only on an enabled edge where hcnt wraps. At V_TOTAL-1 it wraps to 0.
- All outputs are registered and decoded from the next counter values, so they are mutually aligned with hcnt/vcnt. There is no skew between sync, de and the coordinates.
- de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- hsync = HS_POL when hcnt is in the sync range, else ~HS_POL. vsync follows the same rule with vcnt and VS_POL.
- vsync transitions together with hsync/hcnt at the line boundary, i.e. when hcnt becomes 0.
- line_start and frame_start are set only on enabled edges that produce hcnt=0 (and vcnt=0 for frame_start). They clear on the next clk edge regardless of pix_en, so each pulse lasts exactly one clk.
- pix_en=0: counters, hsync, vsync and de hold their values; strobes clear.
- resync=1 (priority over pix_en, below rst): on the next clk edge every output takes its reset value. The next enabled edge then starts a new frame at (0,0) with frame_start=1.
- Comparisons use equality/range decode on CW-bit unsigned values; no signed arithmetic.

## Timing
- Reset values, which are the decode of position (H_TOTAL-1, V_TOTAL-1):
  - hcnt = H_TOTAL-1, vcnt = V_TOTAL-1
  - de = 0, hsync = ~HS_POL, vsync = ~VS_POL
  - line_start = 0, frame_start = 0
- Latency: the first enabled edge after reset or resync gives hcnt=0, vcnt=0, de=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: outputs return to their reset values asynchronously. There is no partial-line recovery; after release, a full frame starts on the first enabled edge.
- Frame period = H_TOTAL*V_TOTAL enabled edges (420000); line period = H_TOTAL enabled edges.
- resync and pix_en high on the same edge: resync wins and the counters do not advance.

## Test plan
- Reset, then pix_en=1 continuously → first edge: (0,0), de=1, frame_start=1. frame_start recurs every 420000 clks; line_start recurs every 800 clks.
- Defaults over one full frame:
  - hsync low exactly on hcnt 656..751
  - vsync low exactly on vcnt 490..491
  - de high for 307200 clks per frame
- pix_en toggling 1,0,1,0 → counters advance every other clk. Strobes last one clk only. hsync and de hold during the disabled clks.
- HS_POL=1, VS_POL=1 with a 1280x720 parameter set (110/40/220, 5/5/20) → H_TOTAL 1650, V_TOTAL 750. Sync is active-high on hcnt 1390..1429 and vcnt 725..729.
- resync pulsed at (300,100) with pix_en=1 → next clk: outputs at reset values. Following clk: (0,0) with frame_start=1.
- rst asserted asynchronously mid-line (between clk edges) → outputs immediately at reset values. After release, first enabled edge gives frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. A horizontal counter runs over each
//   line, and a vertical counter advances when the horizontal counter wraps.
//   Sync, data-enable and strobe outputs are decoded from the *next* counter
//   values and registered in the same cycle as the counters. As a result they
//   line up with hcnt/vcnt and do not skew against them.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   pix_en       pixel-rate enable; counters advance only when high
//   resync       synchronous frame restart (outputs go to their reset values)
//   hsync/vsync  sync outputs, active level set by HS_POL / VS_POL
//   de           high inside the active area
//   hcnt/vcnt    current raster position
//   line_start   one-clk strobe when hcnt becomes 0
//   frame_start  one-clk strobe when (hcnt,vcnt) becomes (0,0)
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          resync,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_LAST_C  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
  // Sync windows are [start, end) so the end value stays below 2^CW.
  localparam logic [CW-1:0] H_SS_C    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE_C    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS_C    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE_C    = CW'(V_ACTIVE + V_FP + V_SYNC);

  // True when pos lies in the half-open window [lo, hi).
  function automatic logic in_window(input logic [CW-1:0] pos,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  logic          h_wrap_s;
  logic [CW-1:0] h_nxt_s;
  logic [CW-1:0] v_nxt_s;
  logic          de_nxt_s;
  logic          hsync_nxt_s;
  logic          vsync_nxt_s;
  logic          line_nxt_s;
  logic          frame_nxt_s;

  // Next raster position and the output decode for that position.
  always_comb begin
    h_wrap_s    = (hcnt == H_LAST_C);
    h_nxt_s     = hcnt;
    v_nxt_s     = vcnt;
    hsync_nxt_s = ~HS_POL;
    vsync_nxt_s = ~VS_POL;

    if (h_wrap_s) begin
      h_nxt_s = ZERO_C;
      if (vcnt == V_LAST_C) begin
        v_nxt_s = ZERO_C;
      end else begin
        v_nxt_s = vcnt + ONE_C;
      end
    end else begin
      h_nxt_s = hcnt + ONE_C;
      v_nxt_s = vcnt;
    end

    de_nxt_s = (h_nxt_s < H_ACT_C) && (v_nxt_s < V_ACT_C);

    if (in_window(h_nxt_s, H_SS_C, H_SE_C)) begin
      hsync_nxt_s = HS_POL;
    end else begin
      hsync_nxt_s = ~HS_POL;
    end

    if (in_window(v_nxt_s, V_SS_C, V_SE_C)) begin
      vsync_nxt_s = VS_POL;
    end else begin
      vsync_nxt_s = ~VS_POL;
    end

    line_nxt_s  = (h_nxt_s == ZERO_C);
    frame_nxt_s = (h_nxt_s == ZERO_C) && (v_nxt_s == ZERO_C);
  end

  // Counter and output registers. Reset and resync both park the raster on
  // its last position, so the first enabled edge lands on (0,0) and fires
  // frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt        <= H_LAST_C;
      vcnt        <= V_LAST_C;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (resync) begin
      hcnt        <= H_LAST_C;
      vcnt        <= V_LAST_C;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hcnt        <= h_nxt_s;
      vcnt        <= v_nxt_s;
      de          <= de_nxt_s;
      hsync       <= hsync_nxt_s;
      vsync       <= vsync_nxt_s;
      line_start  <= line_nxt_s;
      frame_start <= frame_nxt_s;
    end else begin
      // Position holds; strobes last exactly one clk.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct {
    int   h;
    int   v;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } out_t;

  typedef struct {
    logic pe;
    logic rs;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic resync;

  // Default 640x480 instance
  logic d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_h, d_v;
  // 1280x720, active-high syncs
  logic w_hs, w_vs, w_de, w_ls, w_fs;
  logic [10:0] w_h, w_v;
  // Tiny raster so whole frames fit in a short run
  logic s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0] s_h, s_v;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pix_en(pix_en), .resync(resync),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .hcnt(d_h), .vcnt(d_v),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720), .V_FP(5), .V_SYNC(5), .V_BP(20),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) u_hd (
    .clk(clk), .rst(rst), .pix_en(pix_en), .resync(resync),
    .hsync(w_hs), .vsync(w_vs), .de(w_de), .hcnt(w_h), .vcnt(w_v),
    .line_start(w_ls), .frame_start(w_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(4)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .resync(resync),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .hcnt(s_h), .vcnt(s_v),
    .line_start(s_ls), .frame_start(s_fs)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_edges  = 0;   // enabled edges since reset/resync
  bit strobe   = 1'b0; // last edge was an enabled advance

  // Reference: position is simply (n-1) mod frame size, laid out row-major.
  function automatic out_t model(input int n, input bit st,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp);
    out_t o;
    int ht, vt, k;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (n == 0) begin
      o.h = ht - 1;
      o.v = vt - 1;
    end else begin
      k   = (n - 1) % (ht * vt);
      o.h = k % ht;
      o.v = k / ht;
    end
    o.de = (o.h < ha) && (o.v < va);
    o.hs = (o.h >= ha + hf && o.h < ha + hf + hsw) ? hp : !hp;
    o.vs = (o.v >= va + vf && o.v < va + vf + vsw) ? vp : !vp;
    o.ls = st && (o.h == 0);
    o.fs = st && (o.h == 0) && (o.v == 0);
    return o;
  endfunction

  function automatic out_t act_d();
    out_t o;
    o.h = int'(d_h); o.v = int'(d_v); o.de = d_de; o.hs = d_hs; o.vs = d_vs;
    o.ls = d_ls; o.fs = d_fs;
    return o;
  endfunction

  function automatic out_t act_w();
    out_t o;
    o.h = int'(w_h); o.v = int'(w_v); o.de = w_de; o.hs = w_hs; o.vs = w_vs;
    o.ls = w_ls; o.fs = w_fs;
    return o;
  endfunction

  function automatic out_t act_s();
    out_t o;
    o.h = int'(s_h); o.v = int'(s_v); o.de = s_de; o.hs = s_hs; o.vs = s_vs;
    o.ls = s_ls; o.fs = s_fs;
    return o;
  endfunction

  task automatic check(input string name, input out_t e, input out_t a);
    checks++;
    if (a.h !== e.h || a.v !== e.v || a.de !== e.de || a.hs !== e.hs ||
        a.vs !== e.vs || a.ls !== e.ls || a.fs !== e.fs) begin
      failures++;
      $display("FAIL %s t=%0t: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               name, $time, a.h, a.v, a.de, a.hs, a.vs, a.ls, a.fs,
               e.h, e.v, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_def"},   model(n_edges, strobe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0), act_d());
    check({tag, "_hd"},    model(n_edges, strobe, 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1), act_w());
    check({tag, "_small"}, model(n_edges, strobe, 6, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b1), act_s());
  endtask

  // One clk: drive inputs, advance the reference, compare #1 after the edge.
  task automatic step(input logic pe, input logic rs, input string tag);
    pix_en = pe;
    resync = rs;
    @(posedge clk);
    if (rst || rs) begin
      n_edges = 0;
      strobe  = 1'b0;
    end else if (pe) begin
      n_edges++;
      strobe = 1'b1;
    end else begin
      strobe = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  vec_t tbl[9];
  int dls, dhs, dde, wls, whs, wde, sfs, sls, sde, svs;

  initial begin
    // Hand-derived sequence for the tiny raster (H 13, V 8, hsync low 8..10,
    // vsync high on lines 5..6). Reset position is (12,7).
    tbl[0] = '{1'b1, 1'b0, '{0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};
    tbl[1] = '{1'b0, 1'b0, '{0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[2] = '{1'b1, 1'b0, '{1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{1'b0, 1'b0, '{1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[4] = '{1'b1, 1'b1, '{12, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{1'b1, 1'b0, '{0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};
    tbl[6] = '{1'b0, 1'b1, '{12, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[7] = '{1'b0, 1'b0, '{12, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[8] = '{1'b1, 1'b0, '{0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};

    rst    = 1'b1;
    pix_en = 1'b0;
    resync = 1'b0;
    #12;
    check_all("reset");
    #10;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].pe, tbl[i].rs, "tbl_model");
      check($sformatf("tbl_%0d", i), tbl[i].exp, act_s());
    end

    // Continuous run from a fresh frame, counting pulses and active levels.
    step(1'b0, 1'b1, "resync");
    dls = 0; dhs = 0; dde = 0; wls = 0; whs = 0; wde = 0;
    sfs = 0; sls = 0; sde = 0; svs = 0;
    for (int i = 0; i < 2400; i++) begin
      step(1'b1, 1'b0, "run");
      if (d_ls) dls++;
      if (!d_hs) dhs++;
      if (d_de) dde++;
      if (w_ls) wls++;
      if (w_hs) whs++;
      if (w_de) wde++;
      if (s_fs) sfs++;
      if (s_ls) sls++;
      if (s_de) sde++;
      if (s_vs) svs++;
    end
    check_cnt("def_line_starts", dls, 3);
    check_cnt("def_hsync_low", dhs, 3 * 96);
    check_cnt("def_de_high", dde, 3 * 640);
    check_cnt("hd_line_starts", wls, 2);
    check_cnt("hd_hsync_high", whs, 40);
    check_cnt("hd_de_high", wde, 1280 + 750);
    check_cnt("small_frame_starts", sfs, 24);
    check_cnt("small_line_starts", sls, 185);
    check_cnt("small_de_high", sde, 23 * 24 + 6);
    check_cnt("small_vsync_high", svs, 23 * 26);

    // Random enable pattern with occasional resync.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0), "rand");
    end

    // Asynchronous reset between edges, mid-frame.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "pre_rst");
    #3;
    rst = 1'b1;
    n_edges = 0;
    strobe  = 1'b0;
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #3;
    rst = 1'b0;
    step(1'b1, 1'b0, "post_rst");
    checks++;
    if (!(s_fs && d_fs && w_fs)) begin
      failures++;
      $display("FAIL post_rst_frame_start: got def=%b hd=%b small=%b, want 1 1 1", d_fs, w_fs, s_fs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
